// File: rtl/updown_counter_gen.sv
// Prescaled up/down counter with run/stop FSM, clear, saturating load and wrap pulse.
// Optional display freeze (lap hold) enabled by defining LAP_HOLD_EN.
module updown_counter_gen #(
  parameter int CLK_DIV   = 10_000_000,
  parameter int MAX_COUNT = 9999,
  parameter int CNT_W     = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run_stop,
  input  logic             i_clear,
  input  logic             i_mode,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_lap,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_disp,
  output logic             o_tc,
  output logic             o_running
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_COUNT);

  typedef enum logic {STOP, RUN} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_step;
  logic [CNT_W-1:0] load_sat;
  logic             wrap;
  logic             tc;

  always_ff @(posedge clk) begin
    if (reset) state <= STOP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    o_running = (state == RUN);
    if (i_run_stop) state_nx = (state == RUN) ? STOP : RUN;
  end

  always_comb begin
    count_step = count;
    wrap       = 1'b0;
    load_sat   = (i_load_val > MAX_C) ? MAX_C : i_load_val;
    if (!i_mode) begin
      if (count == MAX_C) begin
        count_step = '0;
        wrap       = 1'b1;
      end else begin
        count_step = count + CNT_W'(1);
      end
    end else begin
      if (count == '0) begin
        count_step = MAX_C;
        wrap       = 1'b1;
      end else begin
        count_step = count - CNT_W'(1);
      end
    end
  end

  // Clear and load both restart the prescaler and swallow any pending tick.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      presc <= '0;
      tick  <= 1'b0;
      count <= '0;
      tc    <= 1'b0;
    end else if (i_load) begin
      presc <= '0;
      tick  <= 1'b0;
      count <= load_sat;
      tc    <= 1'b0;
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
      if (state == RUN) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
        if (tick) begin
          count <= count_step;
          tc    <= wrap;
        end
      end
    end
  end

  assign o_count = count;
  assign o_tc    = tc;

`ifdef LAP_HOLD_EN
  logic             frozen;
  logic [CNT_W-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      frozen <= 1'b0;
      hold   <= '0;
    end else if (i_lap) begin
      frozen <= ~frozen;
      if (!frozen) hold <= count;
    end
  end

  assign o_disp = frozen ? hold : count;
`else
  logic unused_lap;
  assign unused_lap = i_lap;
  assign o_disp     = count;
`endif

endmodule
